// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW operand forwarding from EX/MEM and MEM/WB, feeding the ALU.
// Define FWD_BYPASS_EN to enable the forward mux; without it, every hazard on an in-flight writer stalls instead.
module ex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_cmd,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              exm_we,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_res,
    input  logic              mwb_we,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_cmd,
    output logic              ex_valid,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_st_data,
    output logic              load_use_haz
);

    typedef struct packed {
        logic              valid;
        logic [3:0]        cmd;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              reg_we;
        logic              mem_rd;
        logic              mem_wr;
    } idex_t;

    idex_t idex_d;
    idex_t idex_q;

    // NOTE: every field of idex_d gets a value on every path (hold by default), so no latch is inferred.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d.valid  = 1'b0;
            idex_d.reg_we = 1'b0;
            idex_d.mem_rd = 1'b0;
            idex_d.mem_wr = 1'b0;
            idex_d.cmd    = 4'b0000;
        end else if (!stall) begin
            idex_d.valid   = id_valid;
            idex_d.cmd     = id_cmd;
            idex_d.rs_val  = id_rs_val;
            idex_d.rt_val  = id_rt_val;
            idex_d.imm     = id_imm;
            idex_d.use_imm = id_use_imm;
            idex_d.rs      = id_rs;
            idex_d.rt      = id_rt;
            idex_d.rd      = id_rd;
            idex_d.reg_we  = id_reg_we & id_valid;
            idex_d.mem_rd  = id_mem_rd & id_valid;
            idex_d.mem_wr  = id_mem_wr & id_valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

`ifdef FWD_BYPASS_EN
    // EX/MEM is the younger result, so it wins over MEM/WB; r0 is never bypassed.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] src,
                                              input logic [DATA_W-1:0] reg_val);
        if (exm_we && exm_rd == src && src != '0)
            return exm_res;
        else if (mwb_we && mwb_rd == src && src != '0)
            return mwb_data;
        else
            return reg_val;
    endfunction

    always_comb begin
        rs_fwd = fwd(idex_q.rs, idex_q.rs_val);
        rt_fwd = fwd(idex_q.rt, idex_q.rt_val);
    end
`else
    always_comb begin
        rs_fwd = idex_q.rs_val;
        rt_fwd = idex_q.rt_val;
    end
`endif

    always_comb begin
        alu_a      = rs_fwd;
        alu_b      = idex_q.use_imm ? idex_q.imm : rt_fwd;
        ex_st_data = rt_fwd;
        alu_cmd    = idex_q.cmd;
        ex_valid   = idex_q.valid;
        ex_reg_we  = idex_q.valid & idex_q.reg_we;
        ex_mem_rd  = idex_q.valid & idex_q.mem_rd;
        ex_mem_wr  = idex_q.valid & idex_q.mem_wr;
        ex_rd      = idex_q.rd;
    end

    // rt only matters when it feeds the ALU or supplies store data.
    logic id_rt_used;
    logic ex_load_match;
    assign id_rt_used    = !id_use_imm | id_mem_wr;
    assign ex_load_match = idex_q.valid & idex_q.mem_rd & (idex_q.rd != '0) & id_valid &
                           ((idex_q.rd == id_rs) | ((idex_q.rd == id_rt) & id_rt_used));

`ifdef FWD_BYPASS_EN
    assign load_use_haz = ex_load_match;
`else
    logic ex_wr_match;
    logic exm_wr_match;
    assign ex_wr_match  = idex_q.valid & idex_q.reg_we & (idex_q.rd != '0) & id_valid &
                          ((idex_q.rd == id_rs) | ((idex_q.rd == id_rt) & id_rt_used));
    assign exm_wr_match = exm_we & (exm_rd != '0) & id_valid &
                          ((exm_rd == id_rs) | ((exm_rd == id_rt) & id_rt_used));
    assign load_use_haz = ex_load_match | ex_wr_match | exm_wr_match;

    // Without the bypass these inputs have no consumer; they stay on the port list for a uniform interface.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = &{1'b0, exm_res, mwb_we, mwb_rd, mwb_data};
`endif

endmodule
